uart_tx_arb: RTL

Two-requester, message-atomic round-robin arbiter that shares the single UART transmit path between a console source and a debug/monitor source. It sits directly in front of the `uart` block, driving `wr_uart`/`w_data` and honouring `tx_full`. Each requester streams bytes with a valid/ready handshake and marks the final byte of a message with `last`. The grant is held until that byte is accepted, so messages from the two sources never interleave on the serial line.

---
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester, message-atomic round-robin arbiter in front of the uart TX FIFO.
// Optional stall timeout that revokes a silent grant: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 255,
    parameter int TO_BIT  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid0,
    input  logic            valid1,
    input  logic [DBIT-1:0] data0,
    input  logic [DBIT-1:0] data1,
    input  logic            last0,
    input  logic            last1,
    output logic            ready0,
    output logic            ready1,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    input  logic            tx_full,
    output logic [1:0]      gnt,
    output logic            to_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   pri_q, pri_d;
    logic   timeout_hit;

    // The timeout counter must be able to hold TIMEOUT itself.
    if ((1 << TO_BIT) <= TIMEOUT) begin : g_bad_to_bit
        $error("uart_tx_arb: TO_BIT too narrow for TIMEOUT");
    end

    assign ready0  = (state_q == G0) & valid0 & ~tx_full;
    assign ready1  = (state_q == G1) & valid1 & ~tx_full;
    assign wr_uart = ready0 | ready1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        gnt     = 2'b00;
        w_data  = '0;
        case (state_q)
            IDLE: begin
                if (valid0 && valid1) begin
                    state_d = pri_q ? G1 : G0;
                end else if (valid0) begin
                    state_d = G0;
                end else if (valid1) begin
                    state_d = G1;
                end
            end
            G0: begin
                gnt    = 2'b01;
                w_data = data0;
                // Handing straight to a waiting peer avoids an idle bubble.
                if (ready0 && last0) begin
                    pri_d   = 1'b1;
                    state_d = valid1 ? G1 : IDLE;
                end else if (timeout_hit) begin
                    pri_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            G1: begin
                gnt    = 2'b10;
                w_data = data1;
                if (ready1 && last1) begin
                    pri_d   = 1'b0;
                    state_d = valid0 ? G0 : IDLE;
                end else if (timeout_hit) begin
                    pri_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
    logic              granted;
    logic              cur_valid;

    assign granted     = (state_q == G0) | (state_q == G1);
    assign cur_valid   = (state_q == G0) ? valid0 : valid1;
    // Back-pressure freezes the count rather than advancing or revoking.
    assign timeout_hit = granted & ~cur_valid & ~tx_full
                         & (to_cnt_q == TO_BIT'(TIMEOUT));
    assign to_tick     = timeout_hit;

    always_comb begin
        to_cnt_d = '0;
        if (granted && !cur_valid && (state_d == state_q)) begin
            if (tx_full) begin
                to_cnt_d = to_cnt_q;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_tick     = 1'b0;
`endif

endmodule
